// File: rtl/ktc_mem_pkg.sv
// ktc_mem_pkg: shared types and constants for the ktc16 memory responder.
package ktc_mem_pkg;

    typedef enum logic {LOAD, RUN} ld_state_t;

    localparam int          HW              = 16;
    localparam logic [15:0] IO_ADDR_DEFAULT = 16'hFFFF;

endpackage

// File: rtl/ktc_boot_loader.sv
// ktc_boot_loader: boot FSM filling RAM from a valid/ready stream while holding the core in reset.
module ktc_boot_loader
    import ktc_mem_pkg::*;
#(
    parameter int DEPTH_LOG2 = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ld_valid,
    input  logic [HW-1:0]         ld_data,
    input  logic                  ld_last,
    output logic                  ld_ready,
    output logic                  cpu_reset,
    output logic [DEPTH_LOG2:0]   load_count,
    output logic                  load_ovf,
    output logic                  we,
    output logic [DEPTH_LOG2-1:0] waddr,
    output logic [HW-1:0]         wdata
);

    ld_state_t             state_q;
    logic [DEPTH_LOG2-1:0] ptr_q;
    logic [DEPTH_LOG2:0]   count_q;
    logic                  ovf_q;
    logic                  cpu_reset_q;
    logic                  accept;

    assign ld_ready   = (state_q == LOAD) & ~reset;
    assign accept     = ld_valid & ld_ready;
    assign cpu_reset  = cpu_reset_q;
    assign load_count = count_q;
    assign load_ovf   = ovf_q;
    assign we         = accept;
    assign waddr      = ptr_q;
    assign wdata      = ld_data;

    // Leaving LOAD on the top slot without ld_last means the image did not fit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= LOAD;
            ptr_q       <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            cpu_reset_q <= 1'b1;
        end else if (accept) begin
            ptr_q   <= ptr_q + DEPTH_LOG2'(1);
            count_q <= count_q + (DEPTH_LOG2 + 1)'(1);
            if (ld_last | (&ptr_q)) begin
                state_q     <= RUN;
                cpu_reset_q <= 1'b0;
                ovf_q       <= ~ld_last;
            end
        end
    end

endmodule

// File: rtl/ktc_mem.sv
// ktc_mem: halfword RAM, memory-mapped output register and boot loader behind the ktc16 memory port.
module ktc_mem
    import ktc_mem_pkg::*;
#(
    parameter int          DEPTH_LOG2 = 12,
    parameter logic [15:0] IO_ADDR    = IO_ADDR_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [15:0]         addr,
    input  logic [HW-1:0]       wd,
    input  logic                memwrite,
    output logic [2*HW-1:0]     rd,
    output logic                cpu_reset,
    input  logic                ld_valid,
    output logic                ld_ready,
    input  logic [HW-1:0]       ld_data,
    input  logic                ld_last,
    output logic [HW-1:0]       io_out,
    output logic [DEPTH_LOG2:0] load_count,
    output logic                load_ovf
);

    logic [HW-1:0]         mem [2**DEPTH_LOG2];
    logic [HW-1:0]         io_q;
    logic                  ld_we;
    logic [DEPTH_LOG2-1:0] ld_waddr;
    logic [HW-1:0]         ld_wdata;
    logic                  core_wr;
    logic                  ram_we;
    logic [DEPTH_LOG2-1:0] ram_waddr;
    logic [HW-1:0]         ram_wdata;
    logic [15:0]           a1;

    ktc_boot_loader #(.DEPTH_LOG2(DEPTH_LOG2)) u_loader (
        .clk        (clk),
        .reset      (reset),
        .ld_valid   (ld_valid),
        .ld_data    (ld_data),
        .ld_last    (ld_last),
        .ld_ready   (ld_ready),
        .cpu_reset  (cpu_reset),
        .load_count (load_count),
        .load_ovf   (load_ovf),
        .we         (ld_we),
        .waddr      (ld_waddr),
        .wdata      (ld_wdata)
    );

    // The core owns the write port only once the loader has released it.
    assign core_wr   = ~cpu_reset & memwrite;
    assign ram_we    = ld_we | (core_wr & (addr != IO_ADDR));
    assign ram_waddr = ld_we ? ld_waddr : addr[DEPTH_LOG2-1:0];
    assign ram_wdata = ld_we ? ld_wdata : wd;

    always_ff @(posedge clk) begin
        if (ram_we) mem[ram_waddr] <= ram_wdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) io_q <= '0;
        else if (core_wr & (addr == IO_ADDR)) io_q <= wd;
    end

    assign io_out = io_q;
    assign a1     = addr + 16'd1;
    assign rd     = {(a1 == IO_ADDR) ? io_q : mem[a1[DEPTH_LOG2-1:0]],
                     (addr == IO_ADDR) ? io_q : mem[addr[DEPTH_LOG2-1:0]]};

endmodule

// File: tb/tb_ktc_mem.sv
// tb_ktc_mem: directed checks of boot load, core/IO writes, overflow and reset behaviour.
module tb_ktc_mem;

    logic        clk = 1'b0;
    logic        reset, memwrite, ld_valid, ld_last, ld_ready, cpu_reset, load_ovf;
    logic [15:0] addr, wd, ld_data, io_out;
    logic [31:0] rd;
    logic [12:0] load_count;

    logic        s_reset, s_memwrite, s_ld_valid, s_ld_last, s_ld_ready, s_cpu_reset, s_load_ovf;
    logic [15:0] s_addr, s_wd, s_ld_data, s_io_out;
    logic [31:0] s_rd;
    logic [2:0]  s_load_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ktc_mem dut (
        .clk(clk), .reset(reset), .addr(addr), .wd(wd), .memwrite(memwrite), .rd(rd),
        .cpu_reset(cpu_reset), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
        .ld_last(ld_last), .io_out(io_out), .load_count(load_count), .load_ovf(load_ovf)
    );

    ktc_mem #(.DEPTH_LOG2(2)) dut_s (
        .clk(clk), .reset(s_reset), .addr(s_addr), .wd(s_wd), .memwrite(s_memwrite), .rd(s_rd),
        .cpu_reset(s_cpu_reset), .ld_valid(s_ld_valid), .ld_ready(s_ld_ready), .ld_data(s_ld_data),
        .ld_last(s_ld_last), .io_out(s_io_out), .load_count(s_load_count), .load_ovf(s_load_ovf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1; memwrite = 0; addr = 0; wd = 0; ld_valid = 0; ld_data = 0; ld_last = 0;
        s_reset = 1; s_memwrite = 0; s_addr = 0; s_wd = 0; s_ld_valid = 0; s_ld_data = 0; s_ld_last = 0;
        #2;
        chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("rst_ld_ready", 32'(ld_ready), 32'd0);
        chk("rst_load_count", 32'(load_count), 32'd0);
        chk("rst_load_ovf", 32'(load_ovf), 32'd0);
        chk("rst_io_out", 32'(io_out), 32'd0);
        reset = 0;
        #1;
        chk("load_ld_ready", 32'(ld_ready), 32'd1);

        ld_valid = 1; ld_data = 16'h1111;
        step();
        ld_data = 16'h2222;
        step();
        chk("boot_cpu_reset_held", 32'(cpu_reset), 32'd1);
        ld_data = 16'h3333; ld_last = 1;
        step();
        ld_valid = 0; ld_last = 0;
        chk("boot_cpu_reset_fall", 32'(cpu_reset), 32'd0);
        chk("boot_load_count", 32'(load_count), 32'd3);
        chk("boot_ld_ready_run", 32'(ld_ready), 32'd0);
        chk("boot_load_ovf", 32'(load_ovf), 32'd0);
        addr = 16'd0; #1;
        chk("boot_rd_a0", rd, 32'h2222_1111);
        addr = 16'd1; #1;
        chk("boot_rd_a1", rd, 32'h3333_2222);

        memwrite = 1; addr = 16'd5; wd = 16'h5555;
        step();
        addr = 16'd4; wd = 16'h4444;
        step();
        addr = 16'd5; wd = 16'hBEEF; #1;
        chk("core_same_cycle_old", 32'(rd[15:0]), 32'h5555);
        step();
        memwrite = 0; addr = 16'd4; #1;
        chk("core_write_beef", rd, 32'hBEEF_4444);

        memwrite = 1; addr = 16'h0FFF; wd = 16'h0FFF;
        step();
        addr = 16'hFFFF; wd = 16'h00A5;
        step();
        memwrite = 0;
        chk("io_out_written", 32'(io_out), 32'h00A5);
        addr = 16'h0FFF; #1;
        chk("io_alias_untouched", 32'(rd[15:0]), 32'h0FFF);
        addr = 16'hFFFE; #1;
        chk("io_rd_hi", 32'(rd[31:16]), 32'h00A5);
        addr = 16'hFFFF; #1;
        chk("io_rd_wrap", rd, 32'h1111_00A5);

        ld_valid = 1; ld_data = 16'h9999; ld_last = 1;
        step();
        ld_valid = 0; ld_last = 0;
        chk("run_stream_ignored_cnt", 32'(load_count), 32'd3);
        addr = 16'd0; #1;
        chk("run_stream_ignored_mem", rd, 32'h2222_1111);

        #2 reset = 1; #1;
        chk("run_rst_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("run_rst_io_out", 32'(io_out), 32'd0);
        chk("run_rst_ld_ready", 32'(ld_ready), 32'd0);
        reset = 0;
        memwrite = 1; addr = 16'd0; wd = 16'hDEAD;
        step();
        memwrite = 0; #1;
        chk("load_isolation", 32'(rd[15:0]), 32'h1111);

        ld_valid = 1; ld_data = 16'hAAAA;
        step();
        ld_data = 16'hBBBB;
        step();
        ld_valid = 0;
        chk("midload_count", 32'(load_count), 32'd2);
        #2 reset = 1; #1;
        chk("midrst_count", 32'(load_count), 32'd0);
        chk("midrst_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("midrst_io_out", 32'(io_out), 32'd0);
        chk("midrst_ovf", 32'(load_ovf), 32'd0);
        reset = 0;
        ld_valid = 1; ld_data = 16'h7777; ld_last = 1;
        step();
        ld_valid = 0; ld_last = 0;
        chk("reload_cpu_reset", 32'(cpu_reset), 32'd0);
        chk("reload_count", 32'(load_count), 32'd1);
        addr = 16'd0; #1;
        chk("reload_rd_a0", rd, 32'hBBBB_7777);

        s_reset = 0;
        s_ld_valid = 1;
        for (int i = 1; i <= 4; i++) begin
            s_ld_data = 16'(i * 16'h10);
            step();
            if (i == 3) chk("ovf_still_loading", 32'(s_cpu_reset), 32'd1);
        end
        chk("ovf_run", 32'(s_cpu_reset), 32'd0);
        chk("ovf_flag", 32'(s_load_ovf), 32'd1);
        chk("ovf_count", 32'(s_load_count), 32'd4);
        chk("ovf_ready_low", 32'(s_ld_ready), 32'd0);
        s_addr = 16'd3; #1;
        chk("ovf_rd_wrap", s_rd, 32'h0010_0040);
        s_ld_data = 16'h0050;
        step();
        s_ld_valid = 0;
        chk("ovf_fifth_ignored", 32'(s_load_count), 32'd4);
        s_addr = 16'd0; #1;
        chk("ovf_mem0_kept", 32'(s_rd[15:0]), 32'h0010);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
